row_buffer_writer: RTL and testbench
====================================

Name: row_buffer_writer

Overview:
- Write-side partner of the 3-row line-buffer consumer (three2nine).
- Takes an input feature stream, one channel-group word per beat, and writes padded rows into three rotating row RAM banks.
- Raises Row_Compute_Sign once three rows are resident, then refills the freed bank each time the consumer reports a finished output row.
- Sits between the padding/DMA stream and the row RAMs that feed three2nine's S_Feature.

Parameters:
CHANNEL_IN_NUM, 16, channels per RAM word (channel group)
WIDTH_RAM_SIZE, 12, row RAM address width
WIDTH_FEATURE_SIZE, 12, row/column counter width
WIDTH_CHANNEL_NUM, 10, channel count width
(Derived constant: Width_Data = WIDTH_DATA*PICTURE_NUM*CHANNEL_IN_NUM, taken from the shared Para.v macros.)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
Start  in  1  frame start pulse; honoured only in IDLE
Row_Num_After_Padding  in  WIDTH_FEATURE_SIZE  rows = columns of the padded square map
Channel_In_Num_REG  in  WIDTH_CHANNEL_NUM  input channel count
S_Data  in  Width_Data  stream word, one channel group of one column
S_Valid  in  1  stream valid
S_Ready  out  1  stream ready
Wr_Addr  out  WIDTH_RAM_SIZE  RAM write address, equal to col*CG+cg
Wr_Data  out  Width_Data  RAM write data
Wr_EN  out  3  one-hot bank write enable
Bank_Base  out  2  bank holding the oldest resident row (0..2)
Row_Compute_Sign  out  1  level: three rows valid, consumer may read
Row_Done  in  1  one-cycle pulse from consumer: an output row is finished
Frame_Done  out  1  one-cycle pulse at end of frame
Err  out  1  sticky protocol error flag

Behaviour:
- Reset (rst=0, async): state IDLE; S_Ready, Wr_EN, Row_Compute_Sign, Frame_Done and Err are 0; Wr_Addr, Wr_Data and Bank_Base are 0; all counters are 0.
- Channel groups per column: CG = Channel_In_Num_REG>>4, forced to 1 if the result is 0. Row length in words is Row_Num_After_Padding*CG.
- Start with Row_Num_After_Padding<3 is ignored and sets Err.
- States:
  - IDLE: on Start, latch the config, clear the counters, set Bank_Base=0 and go to FILL.
  - FILL: S_Ready=1. Each handshake (S_Valid&S_Ready) writes the next word. Rows go to banks 0, 1, 2 in order. After the last word of the third row, go to WAIT.
  - WAIT: S_Ready=0 and Row_Compute_Sign=1. On Row_Done, increment Cnt_Out.
    - If Cnt_Out+1 == Row_Num_After_Padding-2, go to FINISH.
    - Otherwise, if the rows written so far are fewer than Row_Num_After_Padding, set the refill bank to Bank_Base, advance Bank_Base mod 3, clear Row_Compute_Sign and go to REFILL.
  - REFILL: S_Ready=1. Write one row into the refill bank, then go to WAIT.
  - FINISH: clear Row_Compute_Sign, pulse Frame_Done for one cycle, return to IDLE.
- Write timing:
  - Wr_EN, Wr_Addr and Wr_Data are registered and appear exactly one cycle after the handshake.
  - With no handshake, Wr_EN=0 and Wr_Addr/Wr_Data hold.
- Counters:
  - cg counts 0..CG-1, then wraps and increments col.
  - col counts 0..Row_Num_After_Padding-1, then wraps.
  - Address is a linear counter that resets to 0 at each row start. The address width must hold Row_Num_After_Padding*CG; larger configurations are not supported.
- Row_Compute_Sign rises the cycle after the final Wr_EN pulse of the completing row, so the RAM write has landed before the consumer reads.
- Back-pressure: S_Valid may drop mid-row. The counters advance only on a handshake, and no words are lost or duplicated.
- Row_Done received outside WAIT is ignored and sets Err. Row_Done together with Start: Start is ignored because the block is not in IDLE.
- Err clears only on reset.
- Reset mid-frame aborts immediately with no Frame_Done. The next Start begins a clean frame.

Decomposition:
- Shared package (Para.v): WIDTH_DATA, PICTURE_NUM, and the state one-hot localparams (IDLE, FILL, WAIT, REFILL, FINISH).
- One natural sub-module: row_wr_addr_gen, holding the cg/col/address counters with a row_last output.
- The FSM, bank rotation and Err logic stay in the top module.

Test Plan:
- Row_Num=5, Ch=32 (CG=2) -> FILL: 30 handshakes; Wr_EN=001 for Wr_Addr 0..9, then 010, then 100; Row_Compute_Sign=1 one cycle after the 30th Wr_EN; S_Ready=0 afterwards.
- Continue with a Row_Done pulse -> Bank_Base=1, Sign=0; 10 words are written with Wr_EN=001; Sign=1 again; second Row_Done -> refill into bank 1.
- Third Row_Done (Row_Num-2=3 output rows) -> Frame_Done pulses for one cycle, state IDLE, Err=0; 50 total handshakes.
- Random S_Valid duty of 30% -> Wr_Addr sequence identical to the 100% case; one Wr_EN per handshake.
- Row_Done in FILL, and Start with Row_Num=2 -> Err=1, no state change; Err persists until rst=0.
- rst=0 asserted during REFILL at word 4 -> all outputs are 0 immediately; re-Start -> FILL restarts at bank 0, Wr_Addr 0.

Source files
------------

// File: rtl/row_buffer_writer_pkg.sv
// Shared constants, FSM state encoding and small helpers for the row buffer writer.
// Also provides the default widths used by the top and its address generator.
package row_buffer_writer_pkg;

  localparam int WIDTH_DATA         = 8;
  localparam int PICTURE_NUM        = 1;
  localparam int CHANNEL_IN_NUM     = 16;
  localparam int WIDTH_RAM_SIZE     = 12;
  localparam int WIDTH_FEATURE_SIZE = 12;
  localparam int WIDTH_CHANNEL_NUM  = 10;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    FILL   = 5'b00010,
    WAIT   = 5'b00100,
    REFILL = 5'b01000,
    FINISH = 5'b10000
  } state_t;

  function automatic logic [2:0] bank_onehot(input logic [1:0] bank);
    return 3'b001 << bank;
  endfunction

  function automatic logic [1:0] bank_next(input logic [1:0] bank);
    return (bank == 2'd2) ? 2'd0 : bank + 2'd1;
  endfunction

endpackage

// File: rtl/row_wr_addr_gen.sv
// Channel-group / column / linear address counters for one row of writes.
// o_row_last flags the final word of the row so the caller can close it on that handshake.
module row_wr_addr_gen #(
  parameter int WIDTH_RAM_SIZE     = 12,
  parameter int WIDTH_FEATURE_SIZE = 12,
  parameter int WIDTH_CHANNEL_NUM  = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clr,
  input  logic                          i_adv,
  input  logic [WIDTH_CHANNEL_NUM-1:0]  i_cg_num,
  input  logic [WIDTH_FEATURE_SIZE-1:0] i_row_num,
  output logic [WIDTH_RAM_SIZE-1:0]     o_addr,
  output logic                          o_row_last
);

  logic [WIDTH_CHANNEL_NUM-1:0]  r_cg;
  logic [WIDTH_FEATURE_SIZE-1:0] r_col;
  logic [WIDTH_RAM_SIZE-1:0]     r_addr;
  logic                          w_cg_last;
  logic                          w_col_last;

  assign w_cg_last  = (r_cg == i_cg_num - 1'b1);
  assign w_col_last = (r_col == i_row_num - 1'b1);
  assign o_row_last = w_cg_last && w_col_last;
  assign o_addr     = r_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cg   <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else if (i_clr) begin
      r_cg   <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else if (i_adv) begin
      if (w_cg_last) begin
        r_cg  <= '0;
        r_col <= w_col_last ? '0 : r_col + 1'b1;
      end else begin
        r_cg <= r_cg + 1'b1;
      end
      // Address restarts with every row since each row owns a whole bank.
      r_addr <= o_row_last ? '0 : r_addr + 1'b1;
    end
  end

endmodule

// File: rtl/row_buffer_writer.sv
// Writes a padded feature stream into three rotating row banks for the 3-row consumer,
// refilling the oldest bank each time the consumer finishes an output row.
module row_buffer_writer
  import row_buffer_writer_pkg::*;
#(
  parameter int CHANNEL_IN_NUM     = row_buffer_writer_pkg::CHANNEL_IN_NUM,
  parameter int WIDTH_RAM_SIZE     = row_buffer_writer_pkg::WIDTH_RAM_SIZE,
  parameter int WIDTH_FEATURE_SIZE = row_buffer_writer_pkg::WIDTH_FEATURE_SIZE,
  parameter int WIDTH_CHANNEL_NUM  = row_buffer_writer_pkg::WIDTH_CHANNEL_NUM,
  parameter int W_DATA             = WIDTH_DATA * PICTURE_NUM * CHANNEL_IN_NUM
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Start,
  input  logic [WIDTH_FEATURE_SIZE-1:0] Row_Num_After_Padding,
  input  logic [WIDTH_CHANNEL_NUM-1:0]  Channel_In_Num_REG,
  input  logic [W_DATA-1:0]             S_Data,
  input  logic                          S_Valid,
  output logic                          S_Ready,
  output logic [WIDTH_RAM_SIZE-1:0]     Wr_Addr,
  output logic [W_DATA-1:0]             Wr_Data,
  output logic [2:0]                    Wr_EN,
  output logic [1:0]                    Bank_Base,
  output logic                          Row_Compute_Sign,
  input  logic                          Row_Done,
  output logic                          Frame_Done,
  output logic                          Err
);

  localparam int CG_SHIFT = $clog2(CHANNEL_IN_NUM);

  state_t                        r_state, w_state_next;
  logic [WIDTH_FEATURE_SIZE-1:0] r_row_num;
  logic [WIDTH_CHANNEL_NUM-1:0]  r_cg_num;
  logic [1:0]                    r_bank_base, w_bank_base_next;
  logic [1:0]                    r_wr_bank, w_wr_bank_next;
  logic [WIDTH_FEATURE_SIZE-1:0] r_rows_wr, w_rows_wr_next;
  logic [WIDTH_FEATURE_SIZE-1:0] r_cnt_out, w_cnt_out_next;
  logic                          r_sign, w_sign_next;
  logic                          r_frame_done, w_frame_done_next;
  logic                          r_err, w_err_next;
  logic [2:0]                    r_wr_en;
  logic [WIDTH_RAM_SIZE-1:0]     r_wr_addr;
  logic [W_DATA-1:0]             r_wr_data;

  logic                          w_hs;
  logic                          w_start_ok;
  logic                          w_addr_clr;
  logic                          w_row_last;
  logic [WIDTH_RAM_SIZE-1:0]     w_addr;
  logic [WIDTH_CHANNEL_NUM-1:0]  w_cg_raw;
  logic [WIDTH_CHANNEL_NUM-1:0]  w_cg_cfg;
  logic [WIDTH_FEATURE_SIZE-1:0] w_cnt_inc;
  logic [WIDTH_FEATURE_SIZE-1:0] w_out_rows;

  assign S_Ready          = (r_state == FILL) || (r_state == REFILL);
  assign w_hs             = S_Valid && S_Ready;
  assign w_cg_raw         = Channel_In_Num_REG >> CG_SHIFT;
  assign w_cg_cfg         = (w_cg_raw == '0) ? {{(WIDTH_CHANNEL_NUM-1){1'b0}}, 1'b1} : w_cg_raw;
  assign w_cnt_inc        = r_cnt_out + 1'b1;
  assign w_out_rows       = r_row_num - 2'd2;

  assign Wr_EN            = r_wr_en;
  assign Wr_Addr          = r_wr_addr;
  assign Wr_Data          = r_wr_data;
  assign Bank_Base        = r_bank_base;
  assign Row_Compute_Sign = r_sign;
  assign Frame_Done       = r_frame_done;
  assign Err              = r_err;

  row_wr_addr_gen #(
    .WIDTH_RAM_SIZE     (WIDTH_RAM_SIZE),
    .WIDTH_FEATURE_SIZE (WIDTH_FEATURE_SIZE),
    .WIDTH_CHANNEL_NUM  (WIDTH_CHANNEL_NUM)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_addr_clr),
    .i_adv      (w_hs),
    .i_cg_num   (r_cg_num),
    .i_row_num  (r_row_num),
    .o_addr     (w_addr),
    .o_row_last (w_row_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next      = r_state;
    w_bank_base_next  = r_bank_base;
    w_wr_bank_next    = r_wr_bank;
    w_rows_wr_next    = r_rows_wr;
    w_cnt_out_next    = r_cnt_out;
    w_sign_next       = r_sign;
    w_frame_done_next = 1'b0;
    w_err_next        = r_err;
    w_start_ok        = 1'b0;
    w_addr_clr        = 1'b0;

    if (Row_Done && (r_state != WAIT)) w_err_next = 1'b1;

    case (r_state)
      IDLE: begin
        if (Start) begin
          if (Row_Num_After_Padding < 3) begin
            w_err_next = 1'b1;
          end else begin
            w_start_ok       = 1'b1;
            w_addr_clr       = 1'b1;
            w_bank_base_next = 2'd0;
            w_wr_bank_next   = 2'd0;
            w_rows_wr_next   = '0;
            w_cnt_out_next   = '0;
            w_state_next     = FILL;
          end
        end
      end
      FILL: begin
        if (w_hs && w_row_last) begin
          w_rows_wr_next = r_rows_wr + 1'b1;
          if (r_wr_bank == 2'd2) w_state_next = WAIT;
          else                   w_wr_bank_next = bank_next(r_wr_bank);
        end
      end
      WAIT: begin
        // Sign is set from inside WAIT so it trails the final write enable by one cycle.
        w_sign_next = 1'b1;
        if (Row_Done) begin
          w_cnt_out_next = w_cnt_inc;
          if (w_cnt_inc == w_out_rows) begin
            w_sign_next       = 1'b0;
            w_frame_done_next = 1'b1;
            w_state_next      = FINISH;
          end else if (r_rows_wr < r_row_num) begin
            w_sign_next      = 1'b0;
            w_wr_bank_next   = r_bank_base;
            w_bank_base_next = bank_next(r_bank_base);
            w_addr_clr       = 1'b1;
            w_state_next     = REFILL;
          end
        end
      end
      REFILL: begin
        if (w_hs && w_row_last) begin
          w_rows_wr_next = r_rows_wr + 1'b1;
          w_state_next   = WAIT;
        end
      end
      FINISH: begin
        w_sign_next  = 1'b0;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_num    <= '0;
      r_cg_num     <= '0;
      r_bank_base  <= '0;
      r_wr_bank    <= '0;
      r_rows_wr    <= '0;
      r_cnt_out    <= '0;
      r_sign       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      r_wr_en      <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      if (w_start_ok) begin
        r_row_num <= Row_Num_After_Padding;
        r_cg_num  <= w_cg_cfg;
      end
      r_bank_base  <= w_bank_base_next;
      r_wr_bank    <= w_wr_bank_next;
      r_rows_wr    <= w_rows_wr_next;
      r_cnt_out    <= w_cnt_out_next;
      r_sign       <= w_sign_next;
      r_frame_done <= w_frame_done_next;
      r_err        <= w_err_next;
      r_wr_en      <= w_hs ? bank_onehot(r_wr_bank) : 3'b000;
      if (w_hs) begin
        r_wr_addr <= w_addr;
        r_wr_data <= S_Data;
      end
    end
  end

endmodule

// File: tb/tb_row_buffer_writer.sv
// Directed bench for row_buffer_writer: fill, refill rotation, back-pressure, errors and reset abort.
module tb_row_buffer_writer;
  import row_buffer_writer_pkg::*;

  localparam int WD = WIDTH_DATA * PICTURE_NUM * CHANNEL_IN_NUM;

  logic                          clk;
  logic                          rst;
  logic                          Start;
  logic [WIDTH_FEATURE_SIZE-1:0] Row_Num_After_Padding;
  logic [WIDTH_CHANNEL_NUM-1:0]  Channel_In_Num_REG;
  logic [WD-1:0]                 S_Data;
  logic                          S_Valid;
  logic                          S_Ready;
  logic [WIDTH_RAM_SIZE-1:0]     Wr_Addr;
  logic [WD-1:0]                 Wr_Data;
  logic [2:0]                    Wr_EN;
  logic [1:0]                    Bank_Base;
  logic                          Row_Compute_Sign;
  logic                          Row_Done;
  logic                          Frame_Done;
  logic                          Err;

  typedef struct {
    logic [2:0]                en;
    logic [WIDTH_RAM_SIZE-1:0] addr;
    logic [WD-1:0]             data;
  } wr_t;

  wr_t log_q[$];
  int  checks = 0;
  int  errors = 0;
  int  word_tag = 0;

  row_buffer_writer dut (
    .clk                   (clk),
    .rst                   (rst),
    .Start                 (Start),
    .Row_Num_After_Padding (Row_Num_After_Padding),
    .Channel_In_Num_REG    (Channel_In_Num_REG),
    .S_Data                (S_Data),
    .S_Valid               (S_Valid),
    .S_Ready               (S_Ready),
    .Wr_Addr               (Wr_Addr),
    .Wr_Data               (Wr_Data),
    .Wr_EN                 (Wr_EN),
    .Bank_Base             (Bank_Base),
    .Row_Compute_Sign      (Row_Compute_Sign),
    .Row_Done              (Row_Done),
    .Frame_Done            (Frame_Done),
    .Err                   (Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (Wr_EN !== 3'b000) log_q.push_back('{Wr_EN, Wr_Addr, Wr_Data});
  end

  function automatic logic [WD-1:0] tag_data(input int t);
    logic [7:0] b;
    b = t[7:0];
    return {(WD/8){b}};
  endfunction

  task automatic do_reset();
    rst = 1'b0; Start = 1'b0; S_Valid = 1'b0; Row_Done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start(input int rows, input int ch);
    @(negedge clk);
    Start = 1'b1;
    Row_Num_After_Padding = WIDTH_FEATURE_SIZE'(rows);
    Channel_In_Num_REG = WIDTH_CHANNEL_NUM'(ch);
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic pulse_row_done();
    @(negedge clk);
    Row_Done = 1'b1;
    @(negedge clk);
    Row_Done = 1'b0;
  endtask

  // Drives words until n handshakes are committed; a handshake is counted when valid meets ready before the edge.
  task automatic send_words(input int n, input int duty);
    int k;
    int cyc;
    k = 0; cyc = 0;
    while (k < n && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      S_Valid = ($urandom_range(0, 99) < duty);
      S_Data  = tag_data(word_tag);
      if (S_Valid && S_Ready) begin
        k++;
        word_tag++;
      end
    end
    @(posedge clk);
    #1 S_Valid = 1'b0;
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL send_words: handshakes=%0d required=%0d", k, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; Start = 1'b0; S_Valid = 1'b0; Row_Done = 1'b0; S_Data = '0;
    Row_Num_After_Padding = '0; Channel_In_Num_REG = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({S_Ready, Wr_EN, Row_Compute_Sign, Frame_Done, Err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0", {S_Ready, Wr_EN, Row_Compute_Sign, Frame_Done, Err});
    end
    checks++;
    if (Wr_Addr !== '0 || Wr_Data !== '0 || Bank_Base !== 2'd0) begin
      errors++;
      $display("FAIL reset_data: addr=%0d data=%h base=%0d required 0", Wr_Addr, Wr_Data, Bank_Base);
    end
    rst = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_fill_refill();
    logic [2:0] exp_en;
    log_q.delete();
    word_tag = 0;
    pulse_start(5, 32);
    send_words(30, 100);
    @(negedge clk);
    checks++;
    if (Wr_EN !== 3'b100 || Wr_Addr !== 12'd9 || Row_Compute_Sign !== 1'b0 || S_Ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_last: en=%b addr=%0d sign=%b rdy=%b required 100/9/0/0", Wr_EN, Wr_Addr, Row_Compute_Sign, S_Ready);
    end
    @(negedge clk);
    checks++;
    if (Row_Compute_Sign !== 1'b1 || Wr_EN !== 3'b000 || Wr_Addr !== 12'd9) begin
      errors++;
      $display("FAIL fill_sign: sign=%b en=%b addr=%0d required 1/000/9", Row_Compute_Sign, Wr_EN, Wr_Addr);
    end
    for (int r = 0; r < 2; r++) begin
      pulse_row_done();
      checks++;
      if (Bank_Base !== 2'(r + 1) || Row_Compute_Sign !== 1'b0 || S_Ready !== 1'b1) begin
        errors++;
        $display("FAIL refill%0d_enter: base=%0d sign=%b rdy=%b required %0d/0/1", r, Bank_Base, Row_Compute_Sign, S_Ready, r + 1);
      end
      send_words(10, 100);
      repeat (2) @(negedge clk);
      checks++;
      if (Row_Compute_Sign !== 1'b1) begin
        errors++;
        $display("FAIL refill%0d_sign: sign=%b required 1", r, Row_Compute_Sign);
      end
    end
    pulse_row_done();
    checks++;
    if (Frame_Done !== 1'b1 || Row_Compute_Sign !== 1'b0) begin
      errors++;
      $display("FAIL finish_pulse: frame_done=%b sign=%b required 1/0", Frame_Done, Row_Compute_Sign);
    end
    @(negedge clk);
    checks++;
    if (Frame_Done !== 1'b0 || S_Ready !== 1'b0 || Err !== 1'b0) begin
      errors++;
      $display("FAIL finish_idle: frame_done=%b rdy=%b err=%b required 0/0/0", Frame_Done, S_Ready, Err);
    end
    checks++;
    if (log_q.size() != 50) begin
      errors++;
      $display("FAIL fill_count: writes=%0d required 50", log_q.size());
    end
    for (int i = 0; i < log_q.size() && i < 50; i++) begin
      exp_en = 3'b001 << ((i / 10) % 3);
      checks++;
      if (log_q[i].en !== exp_en || log_q[i].addr !== 12'(i % 10) || log_q[i].data !== tag_data(i)) begin
        errors++;
        $display("FAIL fill_wr%0d: en=%b addr=%0d data=%h required %b/%0d/%h", i, log_q[i].en, log_q[i].addr, log_q[i].data, exp_en, i % 10, tag_data(i));
      end
    end
    $display("test_fill_refill done");
  endtask

  task automatic test_back_pressure();
    logic [2:0] exp_en;
    log_q.delete();
    word_tag = 0;
    pulse_start(5, 32);
    send_words(30, 30);
    repeat (2) @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      pulse_row_done();
      if (r < 2) begin
        send_words(10, 30);
        repeat (2) @(negedge clk);
      end
    end
    checks++;
    if (Frame_Done !== 1'b1) begin
      errors++;
      $display("FAIL bp_finish: frame_done=%b required 1", Frame_Done);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (log_q.size() != 50) begin
      errors++;
      $display("FAIL bp_count: writes=%0d required 50", log_q.size());
    end
    for (int i = 0; i < log_q.size() && i < 50; i++) begin
      exp_en = 3'b001 << ((i / 10) % 3);
      checks++;
      if (log_q[i].en !== exp_en || log_q[i].addr !== 12'(i % 10) || log_q[i].data !== tag_data(i)) begin
        errors++;
        $display("FAIL bp_wr%0d: en=%b addr=%0d data=%h required %b/%0d/%h", i, log_q[i].en, log_q[i].addr, log_q[i].data, exp_en, i % 10, tag_data(i));
      end
    end
    $display("test_back_pressure done");
  endtask

  task automatic test_min_frame();
    logic [2:0] exp_en;
    log_q.delete();
    word_tag = 0;
    pulse_start(3, 0);
    send_words(9, 100);
    repeat (2) @(negedge clk);
    checks++;
    if (Row_Compute_Sign !== 1'b1) begin
      errors++;
      $display("FAIL min_sign: sign=%b required 1", Row_Compute_Sign);
    end
    pulse_row_done();
    checks++;
    if (Frame_Done !== 1'b1 || S_Ready !== 1'b0) begin
      errors++;
      $display("FAIL min_finish: frame_done=%b rdy=%b required 1/0", Frame_Done, S_Ready);
    end
    @(negedge clk);
    checks++;
    if (log_q.size() != 9) begin
      errors++;
      $display("FAIL min_count: writes=%0d required 9", log_q.size());
    end
    for (int i = 0; i < log_q.size() && i < 9; i++) begin
      exp_en = 3'b001 << (i / 3);
      checks++;
      if (log_q[i].en !== exp_en || log_q[i].addr !== 12'(i % 3)) begin
        errors++;
        $display("FAIL min_wr%0d: en=%b addr=%0d required %b/%0d", i, log_q[i].en, log_q[i].addr, exp_en, i % 3);
      end
    end
    $display("test_min_frame done");
  endtask

  task automatic test_errors();
    do_reset();
    pulse_start(2, 32);
    repeat (2) @(negedge clk);
    checks++;
    if (Err !== 1'b1 || S_Ready !== 1'b0) begin
      errors++;
      $display("FAIL err_small_start: err=%b rdy=%b required 1/0", Err, S_Ready);
    end
    do_reset();
    checks++;
    if (Err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b required 0", Err);
    end
    log_q.delete();
    word_tag = 0;
    pulse_start(5, 32);
    send_words(3, 100);
    pulse_row_done();
    checks++;
    if (Err !== 1'b1 || S_Ready !== 1'b1 || Bank_Base !== 2'd0 || Row_Compute_Sign !== 1'b0) begin
      errors++;
      $display("FAIL err_done_in_fill: err=%b rdy=%b base=%0d sign=%b required 1/1/0/0", Err, S_Ready, Bank_Base, Row_Compute_Sign);
    end
    send_words(27, 100);
    @(negedge clk);
    checks++;
    if (Wr_EN !== 3'b100 || Wr_Addr !== 12'd9 || Err !== 1'b1) begin
      errors++;
      $display("FAIL err_fill_resume: en=%b addr=%0d err=%b required 100/9/1", Wr_EN, Wr_Addr, Err);
    end
    $display("test_errors done");
  endtask

  task automatic test_reset_mid_refill();
    do_reset();
    word_tag = 0;
    pulse_start(5, 32);
    send_words(30, 100);
    repeat (2) @(negedge clk);
    pulse_row_done();
    send_words(4, 100);
    @(negedge clk);
    checks++;
    if (Wr_EN !== 3'b001 || Wr_Addr !== 12'd3 || Bank_Base !== 2'd1) begin
      errors++;
      $display("FAIL abort_pre: en=%b addr=%0d base=%0d required 001/3/1", Wr_EN, Wr_Addr, Bank_Base);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({S_Ready, Wr_EN, Row_Compute_Sign, Frame_Done, Err, Bank_Base} !== 9'b0 || Wr_Addr !== '0 || Wr_Data !== '0) begin
      errors++;
      $display("FAIL abort_async: ctrl=%b addr=%0d data=%h required all 0",
               {S_Ready, Wr_EN, Row_Compute_Sign, Frame_Done, Err, Bank_Base}, Wr_Addr, Wr_Data);
    end
    @(negedge clk);
    rst = 1'b1;
    word_tag = 0;
    pulse_start(5, 32);
    send_words(1, 100);
    @(negedge clk);
    checks++;
    if (Wr_EN !== 3'b001 || Wr_Addr !== 12'd0 || Bank_Base !== 2'd0 || Frame_Done !== 1'b0) begin
      errors++;
      $display("FAIL abort_restart: en=%b addr=%0d base=%0d fd=%b required 001/0/0/0", Wr_EN, Wr_Addr, Bank_Base, Frame_Done);
    end
    $display("test_reset_mid_refill done");
  endtask

  initial begin
    test_reset();
    test_fill_refill();
    test_back_pressure();
    test_min_frame();
    test_errors();
    test_reset_mid_refill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
